// File: rtl/amo_seq.sv
// RV64A atomic-memory-operation sequencer: load -> ALU compute -> store on the data port.
// Optional LR/SC reservation support is enabled with the AMO_LRSC_EN macro.
module amo_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic [14:0]     op_ir,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal,
    output logic            misaligned,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_size,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [14:0]     alu_op,
    input  logic [XLEN-1:0] alu_out,
    input  logic            snoop_valid,
    input  logic [XLEN-1:0] snoop_addr
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [4:0] F5_ADD  = 5'b00000, F5_SWAP = 5'b00001, F5_LR   = 5'b00010,
                           F5_SC   = 5'b00011, F5_XOR  = 5'b00100, F5_OR   = 5'b01000,
                           F5_AND  = 5'b01100, F5_MIN  = 5'b10000, F5_MAX  = 5'b10100,
                           F5_MINU = 5'b11000, F5_MAXU = 5'b11100;

    logic [2:0]      state;
    logic [4:0]      f5_q;
    logic [XLEN-1:0] rs2_q, rd_q, wdata_q, addr_q;
    logic            size_q, illegal_q, misaligned_q;
    logic            res_valid;
    logic [XLEN-4:0] res_addr;

    logic [4:0] f5_in;
    logic [2:0] f3_in;
    logic       amo_ok, lrsc_ok, is_sc_in, dec_illegal, dec_misal, res_hit;
    logic       unused_op;

    assign f5_in     = op_ir[14:10];
    assign f3_in     = op_ir[9:7];
    assign unused_op = ^op_ir[6:0];
    assign is_sc_in  = (f5_in == F5_SC);
    assign res_hit   = res_valid && (res_addr == addr[XLEN-1:3]);

`ifdef AMO_LRSC_EN
    assign lrsc_ok = 1'b1;
`else
    assign lrsc_ok = 1'b0;
`endif

    always_comb begin
        amo_ok = 1'b0;
        case (f5_in)
            F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: amo_ok = 1'b1;
            F5_LR, F5_SC:                      amo_ok = lrsc_ok;
            default:                           amo_ok = 1'b0;
        endcase
    end

    assign dec_illegal = !((f3_in == 3'b010) || (f3_in == 3'b011)) || !amo_ok;
    assign dec_misal   = f3_in[0] ? (addr[2:0] != 3'b000) : (addr[1:0] != 2'b00);

    // Word operands: unsigned compares need zero-extended inputs, everything else signed.
    logic            uns;
    logic [2:0]      f3_alu;
    logic [XLEN-1:0] a_ext, b_ext, new_val, old_ld;

    always_comb begin
        uns    = (f5_q == F5_MINU) || (f5_q == F5_MAXU);
        a_ext  = (!size_q && uns) ? {32'b0, rd_q[31:0]} : rd_q;
        b_ext  = size_q ? rs2_q :
                 (uns ? {32'b0, rs2_q[31:0]} : {{32{rs2_q[31]}}, rs2_q[31:0]});
        f3_alu = 3'b000;
        case (f5_q)
            F5_XOR:          f3_alu = 3'b100;
            F5_OR:           f3_alu = 3'b110;
            F5_AND:          f3_alu = 3'b111;
            F5_MIN, F5_MAX:  f3_alu = 3'b010;
            F5_MINU, F5_MAXU: f3_alu = 3'b011;
            default:         f3_alu = 3'b000;
        endcase
        case (f5_q)
            F5_SWAP:          new_val = rs2_q;
            F5_MIN, F5_MINU:  new_val = alu_out[0] ? a_ext : b_ext;
            F5_MAX, F5_MAXU:  new_val = alu_out[0] ? b_ext : a_ext;
            default:          new_val = alu_out;
        endcase
        old_ld = size_q ? mem_rdata : {{32{mem_rdata[31]}}, mem_rdata[31:0]};
    end

    assign alu_a  = (state == S_CALC) ? a_ext : '0;
    assign alu_b  = (state == S_CALC) ? b_ext : '0;
    assign alu_op = (state == S_CALC) ? {5'b0, f3_alu, 7'b0110011} : 15'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            f5_q         <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            size_q       <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    f5_q         <= f5_in;
                    rs2_q        <= rs2;
                    addr_q       <= addr;
                    size_q       <= f3_in[0];
                    illegal_q    <= dec_illegal;
                    misaligned_q <= !dec_illegal && dec_misal;
                    rd_q         <= '0;
                    if (dec_illegal || dec_misal) begin
                        state <= S_RESP;
                    end else if (is_sc_in) begin
                        wdata_q <= rs2;
                        rd_q    <= res_hit ? '0 : {{(XLEN-1){1'b0}}, 1'b1};
                        state   <= res_hit ? S_STORE : S_RESP;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: if (mem_ack) begin
                    rd_q  <= old_ld;
                    state <= (f5_q == F5_LR) ? S_RESP : S_CALC;
                end
                S_CALC: begin
                    wdata_q <= new_val;
                    state   <= S_STORE;
                end
                S_STORE: if (mem_ack) state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AMO_LRSC_EN
    // A reservation set on the same cycle as a matching snoop survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_addr  <= '0;
        end else if (state == S_LOAD && mem_ack && f5_q == F5_LR) begin
            res_valid <= 1'b1;
            res_addr  <= addr_q[XLEN-1:3];
        end else if (state == S_IDLE && req && is_sc_in) begin
            res_valid <= 1'b0;
        end else if (snoop_valid && snoop_addr[XLEN-1:3] == res_addr) begin
            res_valid <= 1'b0;
        end else if (state == S_STORE && mem_ack && addr_q[XLEN-1:3] == res_addr) begin
            res_valid <= 1'b0;
        end
    end
`else
    logic unused_snoop;
    assign res_valid    = 1'b0;
    assign res_addr     = '0;
    assign unused_snoop = ^{snoop_valid, snoop_addr};
`endif

    assign busy       = (state != S_IDLE) || (req && !rst);
    assign done       = (state == S_RESP);
    assign rd_data    = rd_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;
    assign mem_addr   = addr_q;
    assign mem_size   = size_q;
    assign mem_rd     = (state == S_LOAD);
    assign mem_wr     = (state == S_STORE);
    assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_amo_seq.sv
// Directed bench for amo_seq with a behavioural memory (programmable ack delay) and shared ALU.
module tb_amo_seq;
    logic        clk = 1'b0;
    logic        rst, req;
    logic [14:0] op_ir;
    logic [63:0] addr, rs2, rd_data, mem_addr, mem_wdata, mem_rdata;
    logic        busy, done, illegal, misaligned, mem_size, mem_rd, mem_wr, mem_ack;
    logic [63:0] alu_a, alu_b, alu_out, snoop_addr;
    logic [14:0] alu_op;
    logic        snoop_valid;

    int errors = 0;
    int checks = 0;

    int          ack_delay = 0;
    int          req_age = 0;
    logic [63:0] mem_word = 64'd0;
    int          wr_cnt = 0, mem_cyc = 0, glitch = 0, both = 0;
    logic [63:0] last_wdata = 64'd0;
    logic [14:0] last_alu_op = 15'd0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [63:0] prev_addr = 64'd0, prev_wdata = 64'd0;

    amo_seq #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .req(req), .op_ir(op_ir), .addr(addr), .rs2(rs2),
        .busy(busy), .done(done), .rd_data(rd_data), .illegal(illegal),
        .misaligned(misaligned), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = 64'd0;
        case (alu_op[9:7])
            3'b000: alu_out = alu_a + alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            3'b110: alu_out = alu_a | alu_b;
            3'b111: alu_out = alu_a & alu_b;
            3'b010: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 64'd1 : 64'd0;
            3'b011: alu_out = (alu_a < alu_b) ? 64'd1 : 64'd0;
            default: alu_out = 64'd0;
        endcase
    end

    assign mem_rdata = mem_word;
    assign mem_ack   = (mem_rd || mem_wr) && (req_age >= ack_delay);

    always @(posedge clk) begin
        req_age <= (mem_rd || mem_wr) && !mem_ack ? req_age + 1 : 0;
        if (mem_wr && mem_ack) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_rd || mem_wr) mem_cyc <= mem_cyc + 1;
        if (mem_rd && mem_wr) both <= both + 1;
        if ((mem_rd && prev_rd && mem_addr != prev_addr) ||
            (mem_wr && prev_wr && (mem_addr != prev_addr || mem_wdata != prev_wdata)))
            glitch <= glitch + 1;
        if (alu_op != 15'd0) last_alu_op <= alu_op;
        prev_rd    <= mem_rd && !mem_ack;
        prev_wr    <= mem_wr && !mem_ack;
        prev_addr  <= mem_addr;
        prev_wdata <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one request and returns at the negedge of the done cycle (lat = cycles after accept).
    task automatic do_amo(input logic [4:0] f5, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] r2, output int lat);
        @(negedge clk);
        op_ir = {f5, f3, 7'b0101111};
        addr  = a;
        rs2   = r2;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
    endtask

    int lat, w0, m0;

    initial begin
        rst = 1'b1; req = 1'b0; op_ir = '0; addr = '0; rs2 = '0;
        snoop_valid = 1'b0; snoop_addr = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // amoadd.d
        mem_word = 64'd5; w0 = wr_cnt;
        do_amo(5'b00000, 3'b011, 64'h1000, 64'd7, lat);
        check("add_lat", 64'(lat), 64'd4);
        check("add_rd", rd_data, 64'd5);
        check("add_flags", {62'd0, illegal, misaligned}, 64'd0);
        check("add_wdata", last_wdata, 64'd12);
        check("add_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        check("add_alu_op", 64'(last_alu_op), 64'h0033);

        // amomin.w with a negative memory word and junk in the upper half
        mem_word = 64'h12345678_FFFFFFFE;
        do_amo(5'b10000, 3'b010, 64'h1008, 64'd3, lat);
        check("min_rd", rd_data, 64'hFFFFFFFF_FFFFFFFE);
        check("min_wdata", 64'(last_wdata[31:0]), 64'hFFFFFFFE);
        check("min_alu_op", 64'(last_alu_op), 64'h0133);

        // amomaxu.w
        do_amo(5'b11100, 3'b010, 64'h100C, 64'd3, lat);
        check("maxu_wdata", 64'(last_wdata[31:0]), 64'hFFFFFFFE);
        check("maxu_alu_op", 64'(last_alu_op), 64'h01B3);

        // amoswap.d
        mem_word = 64'd5;
        do_amo(5'b00001, 3'b011, 64'h1010, 64'hAA, lat);
        check("swap_wdata", last_wdata, 64'hAA);
        check("swap_rd", rd_data, 64'd5);

        // misaligned amoadd.d
        m0 = mem_cyc;
        do_amo(5'b00000, 3'b011, 64'h1004, 64'd1, lat);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_flag", 64'(misaligned), 64'd1);
        check("mis_illegal", 64'(illegal), 64'd0);
        check("mis_rd", rd_data, 64'd0);
        check("mis_nomem", 64'(mem_cyc - m0), 64'd0);

        // illegal funct5, illegal has priority over misaligned, illegal funct3
        do_amo(5'b11111, 3'b011, 64'h1000, 64'd1, lat);
        check("ill_f5", 64'(illegal), 64'd1);
        check("ill_f5_lat", 64'(lat), 64'd1);
        do_amo(5'b11111, 3'b011, 64'h1003, 64'd1, lat);
        check("ill_prio", {62'd0, illegal, misaligned}, 64'd2);
        do_amo(5'b00000, 3'b000, 64'h1000, 64'd1, lat);
        check("ill_f3", 64'(illegal), 64'd1);
        check("ill_nomem", 64'(mem_cyc - m0), 64'd0);

        // amoand.d with 3-cycle ack delay
        ack_delay = 3; mem_word = 64'hF0F0;
        do_amo(5'b01100, 3'b011, 64'h1018, 64'hFF, lat);
        check("dly_lat", 64'(lat), 64'd10);
        check("dly_rd", rd_data, 64'hF0F0);
        check("dly_wdata", last_wdata, 64'hF0);

        // reset during STORE
        w0 = wr_cnt;
        @(negedge clk);
        op_ir = {5'b01000, 3'b011, 7'b0101111}; addr = 64'h1020; rs2 = 64'h1; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 30 && !mem_wr; i++) @(negedge clk);
        check("rst_reach_store", 64'(mem_wr), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_mem_wr", 64'(mem_wr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_no_store", 64'(wr_cnt - w0), 64'd0);

        // recovery: amoxor.d
        ack_delay = 0; mem_word = 64'hFF;
        do_amo(5'b00100, 3'b011, 64'h1028, 64'h0F, lat);
        check("xor_wdata", last_wdata, 64'hF0);
        check("xor_alu_op", 64'(last_alu_op), 64'h0233);

`ifdef AMO_LRSC_EN
        mem_word = 64'h55;
        do_amo(5'b00010, 3'b011, 64'h2000, 64'd0, lat);
        check("lr_rd", rd_data, 64'h55);
        check("lr_lat", 64'(lat), 64'd2);
        w0 = wr_cnt;
        do_amo(5'b00011, 3'b011, 64'h2000, 64'h77, lat);
        check("sc_ok_rd", rd_data, 64'd0);
        check("sc_ok_wr", 64'(wr_cnt - w0), 64'd1);
        check("sc_ok_wdata", last_wdata, 64'h77);
        do_amo(5'b00010, 3'b011, 64'h2000, 64'd0, lat);
        @(negedge clk);
        snoop_valid = 1'b1; snoop_addr = 64'h2004;
        @(negedge clk);
        snoop_valid = 1'b0;
        w0 = wr_cnt;
        do_amo(5'b00011, 3'b011, 64'h2000, 64'h99, lat);
        check("sc_snoop_rd", rd_data, 64'd1);
        check("sc_snoop_nowr", 64'(wr_cnt - w0), 64'd0);
`else
        m0 = mem_cyc;
        do_amo(5'b00010, 3'b011, 64'h2000, 64'd0, lat);
        check("lr_illegal", 64'(illegal), 64'd1);
        do_amo(5'b00011, 3'b011, 64'h2000, 64'd0, lat);
        check("sc_illegal", 64'(illegal), 64'd1);
        check("lrsc_nomem", 64'(mem_cyc - m0), 64'd0);
`endif

        @(negedge clk);
        check("never_rd_and_wr", 64'(both), 64'd0);
        check("req_stable", 64'(glitch), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
